// File: rtl/rng_share_ctrl.sv
// Shares one 16-bit pseudo-random generator among NREQ round-robin requesters.
// Steps the generator, waits SETTLE cycles, captures 16 or 4 bits, and serialises reseeds.
module rng_share_ctrl #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_wide,
  input  logic            seed_req,
  input  logic [15:0]     seed_val,
  input  logic [15:0]     rng_out,
  input  logic [3:0]      rng_out_4bit,
  output logic            rng_step,
  output logic            rng_load,
  output logic [15:0]     rng_seed,
  output logic [NREQ-1:0] ack,
  output logic [15:0]     data_out,
  output logic            seed_ack,
  output logic            busy,
  output logic [15:0]     grant_count
);

  localparam int          IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U   = NREQ;
  localparam logic [3:0]  SETTLE_W = 4'(SETTLE);

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    STEP,
    WAIT,
    RESP
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   ptr, ptr_nx;
  logic [IW-1:0]   grantee, grantee_nx;
  logic [IW-1:0]   pick;
  logic            pick_valid;
  logic            wide, wide_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            capture;

  // Requester index base+off, wrapped into 0..NREQ-1 (off is always < NREQ).
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ_U) sum = sum - NREQ_U;
    return IW'(sum);
  endfunction

  // Round-robin search: first asserted request at or after ptr, wrapping around.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_valid && req[wrap_idx(ptr, unsigned'(k))]) begin
        pick       = wrap_idx(ptr, unsigned'(k));
        pick_valid = 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    grantee_nx = grantee;
    wide_nx    = wide;
    cnt_nx     = cnt;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (seed_req) begin
          state_nx = SEED;
        end else if (pick_valid) begin
          grantee_nx = pick;
          wide_nx    = req_wide[pick];
          state_nx   = STEP;
        end
      end
      SEED: state_nx = IDLE;
      STEP: begin
        cnt_nx   = SETTLE_W;
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          capture  = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        ptr_nx   = wrap_idx(grantee, 1);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each strobe is high exactly
  // during the cycle the FSM sits in the state that owns it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: reset also clears the datapath registers (data_out, rng_seed,
  // grant_count), not just control, so nothing stale is visible after reset.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state       <= IDLE;
      ptr         <= '0;
      grantee     <= '0;
      wide        <= 1'b0;
      cnt         <= '0;
      rng_step    <= 1'b0;
      rng_load    <= 1'b0;
      rng_seed    <= '0;
      ack         <= '0;
      data_out    <= '0;
      seed_ack    <= 1'b0;
      busy        <= 1'b0;
      grant_count <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      grantee  <= grantee_nx;
      wide     <= wide_nx;
      cnt      <= cnt_nx;
      rng_step <= (state_nx == STEP);
      rng_load <= (state_nx == SEED);
      seed_ack <= (state_nx == SEED);
      busy     <= (state_nx != IDLE);
      if (state_nx == SEED) rng_seed <= seed_val;
      if (capture) data_out <= wide ? rng_out : {12'h000, rng_out_4bit};
      if (state_nx == RESP) begin
        ack         <= NREQ'(1) << grantee;
        grant_count <= grant_count + 16'd1;
      end else begin
        ack <= '0;
      end
    end
  end

  // Protocol invariants on the generator strobes and completion pulses.
  a_strobe_excl : assert property (@(posedge clock) disable iff (!nreset)
    !(rng_step && rng_load));
  a_strobe_gap  : assert property (@(posedge clock) disable iff (!nreset)
    (rng_step || rng_load) |=> !(rng_step || rng_load));
  a_ack_onehot  : assert property (@(posedge clock) disable iff (!nreset)
    $onehot0(ack));
  a_ack_seed    : assert property (@(posedge clock) disable iff (!nreset)
    !((|ack) && seed_ack));

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Randomised scoreboard bench for rng_share_ctrl: a transaction-level model predicts
// each grant/reseed (winner, data, count, cycle) and a monitor checks the DUT against it.
module tb_rng_share_ctrl;

  localparam int NREQ   = 4;
  localparam int SETTLE = 1;
  localparam int NEV    = 60;

  logic            clock = 1'b0;
  logic            nreset;
  logic [NREQ-1:0] req, req_wide;
  logic            seed_req;
  logic [15:0]     seed_val;
  logic [15:0]     rng_out;
  logic [3:0]      rng_out_4bit;
  logic            rng_step, rng_load, seed_ack, busy;
  logic [15:0]     rng_seed, data_out, grant_count;
  logic [NREQ-1:0] ack;

  rng_share_ctrl #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
    .clock        (clock),
    .nreset       (nreset),
    .req          (req),
    .req_wide     (req_wide),
    .seed_req     (seed_req),
    .seed_val     (seed_val),
    .rng_out      (rng_out),
    .rng_out_4bit (rng_out_4bit),
    .rng_step     (rng_step),
    .rng_load     (rng_load),
    .rng_seed     (rng_seed),
    .ack          (ack),
    .data_out     (data_out),
    .seed_ack     (seed_ack),
    .busy         (busy),
    .grant_count  (grant_count)
  );

  initial forever #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] lfsr(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Environment: the shared generator, advanced or loaded by the DUT strobes.
  logic [15:0] gen = 16'hACE1;
  always @(posedge clock) begin
    if (rng_load)      gen <= rng_seed;
    else if (rng_step) gen <= lfsr(gen);
  end
  assign rng_out      = gen;
  assign rng_out_4bit = gen[15:12];

  typedef struct {
    bit          is_seed;
    int          idx;
    logic [15:0] data;
    logic [15:0] gcount;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state.
  logic [NREQ-1:0] pend;
  int              ptr_m;
  bit              seed_pend;
  logic [15:0]     seed_m;
  logic [15:0]     mg;
  logic [15:0]     gc_m;
  bit              last_seed;
  int              cur_w;
  int              dec_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] p, input int start);
    for (int k = 0; k < NREQ; k++)
      if (p[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  // Predict the outcome of the IDLE decision made during cycle idle_cyc.
  task automatic decide(input int idle_cyc, output bit pushed);
    exp_t e;
    pushed  = 1'b1;
    dec_cyc = idle_cyc;
    if (seed_pend) begin
      e.is_seed = 1'b1;
      e.idx     = 0;
      e.data    = seed_m;
      e.gcount  = gc_m;
      e.cyc     = idle_cyc + 1;
      mg        = seed_m;
      last_seed = 1'b1;
    end else if (pend != '0) begin
      int w;
      w         = rr_pick(pend, ptr_m);
      mg        = lfsr(mg);
      gc_m      = gc_m + 16'd1;
      e.is_seed = 1'b0;
      e.idx     = w;
      e.data    = req_wide[w] ? mg : {12'h000, mg[15:12]};
      e.gcount  = gc_m;
      e.cyc     = idle_cyc + 2 + SETTLE;
      ptr_m     = (w + 1) % NREQ;
      cur_w     = w;
      last_seed = 1'b0;
    end else begin
      pushed = 1'b0;
    end
    if (pushed) sb.push_back(e);
  endtask

  task automatic raise_seed();
    seed_val  = 16'($urandom) | 16'h0001;
    seed_m    = seed_val;
    seed_req  = 1'b1;
    seed_pend = 1'b1;
  endtask

  task automatic wait_event(input bit may_seed, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 16 + SETTLE; t++) begin
      @(negedge clock);
      // A reseed raised mid-grant must be held off until the grant completes.
      if (may_seed && !last_seed && !seed_pend && cyc == dec_cyc + 1 && $urandom_range(0, 5) == 0)
        raise_seed();
      if ((|ack) || seed_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("event_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rng_step"},    32'(rng_step),    32'd0);
    check({tag, "_rng_load"},    32'(rng_load),    32'd0);
    check({tag, "_rng_seed"},    32'(rng_seed),    32'd0);
    check({tag, "_ack"},         32'(ack),         32'd0);
    check({tag, "_data_out"},    32'(data_out),    32'd0);
    check({tag, "_seed_ack"},    32'(seed_ack),    32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_grant_count"}, 32'(grant_count), 32'd0);
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on each completion.
  logic prev_act = 1'b0;
  exp_t got;
  always @(negedge clock) begin
    if (cyc > 0) begin
      check("step_load_excl", 32'(rng_step & rng_load), 32'd0);
      check("strobe_spacing", 32'(prev_act & (rng_step | rng_load)), 32'd0);
      check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      check("ack_seed_excl", 32'((|ack) & seed_ack), 32'd0);
      prev_act <= rng_step | rng_load;
      if ((|ack) || seed_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_event", 32'(ack), 32'd0);
        end else begin
          got = sb.pop_front();
          check("event_cycle", 32'(cyc), 32'(got.cyc));
          if (got.is_seed) begin
            check("seed_ack", 32'(seed_ack), 32'd1);
            check("rng_load", 32'(rng_load), 32'd1);
            check("rng_seed", 32'(rng_seed), 32'(got.data));
          end else begin
            check("ack_vec", 32'(ack), 32'(1) << got.idx);
            check("data_out", 32'(data_out), 32'(got.data));
            check("grant_count", 32'(grant_count), 32'(got.gcount));
            check("busy_resp", 32'(busy), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    bit ok, pushed, allow;
    int n_ev;
    nreset    = 1'b0;
    req       = '1;
    req_wide  = '0;
    seed_req  = 1'b0;
    seed_val  = '0;
    pend      = '1;
    ptr_m     = 0;
    seed_pend = 1'b0;
    seed_m    = '0;
    mg        = 16'hACE1;
    gc_m      = '0;
    last_seed = 1'b0;
    cur_w     = 0;
    dec_cyc   = 0;

    // Two reset edges with every request raised: outputs all zero, no step.
    @(negedge clock);
    check_zero("rst1");
    @(negedge clock);
    check_zero("rst2");
    nreset   = 1'b1;
    req_wide = NREQ'($urandom);
    decide(cyc, pushed);

    // Randomised traffic; afterwards drain until the model has nothing pending.
    n_ev = 0;
    ok   = 1'b1;
    while (1) begin
      wait_event(1'b1, ok);
      if (!ok) break;
      n_ev++;
      allow = (n_ev < NEV);
      if (last_seed) begin
        seed_req  = 1'b0;
        seed_pend = 1'b0;
      end else begin
        pend[cur_w] = 1'b0;
      end
      if (allow) begin
        if ($urandom_range(0, 2) != 0) pend = pend | NREQ'($urandom);
        if (!seed_pend && $urandom_range(0, 5) == 0) raise_seed();
        req_wide = NREQ'($urandom);
      end
      req = pend;
      decide(cyc + 1, pushed);
      if (!pushed) begin
        if (!allow) break;
        repeat ($urandom_range(1, 3)) @(negedge clock);
        pend     = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        req      = pend;
        req_wide = NREQ'($urandom);
        decide(cyc, pushed);
      end
    end

    // Reset in the WAIT cycle: grant dropped, pointer and count cleared,
    // then the held requests restart from requester 0.
    if (ok) begin
      @(negedge clock);
      pend     = '1;
      req      = '1;
      req_wide = NREQ'($urandom);
      @(negedge clock);
      check("mid_step", 32'(rng_step), 32'd1);
      @(negedge clock);
      check("mid_busy_wait", 32'(busy), 32'd1);
      nreset = 1'b0;
      @(negedge clock);
      check_zero("mid_rst");
      mg     = lfsr(mg);
      gc_m   = '0;
      ptr_m  = 0;
      nreset = 1'b1;
      decide(cyc, pushed);
      wait_event(1'b0, ok);
      @(negedge clock);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
